// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage parameters and FSM state encoding.
package riscv_fetch_pkg;
  localparam int              XLEN        = 32;
  localparam int              ILEN        = 32;
  localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
  localparam int              FETCH_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO for {pc, instr} entries; pointers wrap modulo DEPTH, flush empties in one cycle.
module riscv_fetch_fifo #(
  parameter int WIDTH = riscv_fetch_pkg::XLEN + riscv_fetch_pkg::ILEN,
  parameter int DEPTH = riscv_fetch_pkg::FETCH_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import riscv_fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/riscv_fetch_unit.sv
// In-order instruction fetch: PC, request issue, response queue, redirect drain.
// Optional same-cycle response bypass when RISCV_FETCH_BYPASS_EN is defined.
module riscv_fetch_unit #(
  parameter int              XLEN     = riscv_fetch_pkg::XLEN,
  parameter int              DEPTH    = riscv_fetch_pkg::FETCH_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_fetch_pkg::RESET_PC)
) (
  input  logic            i_fetch_clk,
  input  logic            i_fetch_rst,
  input  logic            i_fetch_redirect,
  input  logic [XLEN-1:0] i_fetch_redirect_pc,
  output logic            o_fetch_imem_req,
  output logic [XLEN-1:0] o_fetch_imem_addr,
  input  logic            i_fetch_imem_gnt,
  input  logic            i_fetch_imem_rvalid,
  input  logic [31:0]     i_fetch_imem_rdata,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic [31:0]     o_fetch_instr,
  input  logic            i_fetch_ready
);
  import riscv_fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = XLEN + ILEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, redir_pc;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d;

  logic [XLEN-1:0] pcq_mem [DEPTH];
  logic [AW-1:0]   pcq_wr_q, pcq_rd_q;

  logic            fq_push, fq_pop, fq_flush, fq_full, fq_empty;
  logic [CW-1:0]   fq_count;
  logic [EW-1:0]   fq_wdata, fq_rdata;
  logic            redir, grant, rsp, rsp_take, byp;
  logic [CW:0]     inflight;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = ^i_fetch_redirect_pc[1:0];
  assign redir_pc = {i_fetch_redirect_pc[XLEN-1:2], 2'b00};
  assign redir    = i_fetch_redirect && (state_q != IDLE);

  // Queue slots are reserved at grant time so every response has room.
  assign inflight          = {1'b0, fq_count} + {1'b0, out_q};
  assign o_fetch_imem_req  = (state_q == RUN) && !redir && (inflight < (CW+1)'(DEPTH));
  assign o_fetch_imem_addr = pc_q;
  assign grant             = o_fetch_imem_req && i_fetch_imem_gnt;
  assign rsp               = i_fetch_imem_rvalid && (out_q != '0);
  assign rsp_take          = rsp && (state_q == RUN) && !redir;
  assign out_d             = out_q + CW'(grant) - CW'(rsp);

`ifdef RISCV_FETCH_BYPASS_EN
  assign byp = rsp_take && fq_empty;
`else
  assign byp = 1'b0;
`endif

  assign fq_wdata = {pcq_mem[pcq_rd_q], i_fetch_imem_rdata};
  assign fq_push  = rsp_take && !(byp && i_fetch_ready);
  assign fq_pop   = !fq_empty && i_fetch_ready;
  assign fq_flush = redir;

  riscv_fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_fetch_clk),
    .rst_i   (i_fetch_rst),
    .push_i  (fq_push),
    .wdata_i (fq_wdata),
    .pop_i   (fq_pop),
    .flush_i (fq_flush),
    .rdata_o (fq_rdata),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  assign o_fetch_valid = !fq_empty || byp;

  always_comb begin
    o_fetch_pc    = '0;
    o_fetch_instr = '0;
    if (!fq_empty)  {o_fetch_pc, o_fetch_instr} = fq_rdata;
    else if (byp)   {o_fetch_pc, o_fetch_instr} = fq_wdata;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    if (grant) pc_d = pc_q + XLEN'(4);
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redir) begin
          pc_d = redir_pc;
          if (out_d != '0) begin
            disc_d  = out_d;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (redir) pc_d = redir_pc;
        if (rsp)   disc_d = disc_q - CW'(1);
        if (disc_d == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_fetch_clk) begin
    if (i_fetch_rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      pcq_wr_q <= '0;
      pcq_rd_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      if (grant) pcq_wr_q <= pcq_wr_q + AW'(1);
      if (rsp)   pcq_rd_q <= pcq_rd_q + AW'(1);
    end
  end

  // PC of each outstanding request, consumed in order by responses (kept or dropped).
  always_ff @(posedge i_fetch_clk) begin
    if (grant) pcq_mem[pcq_wr_q] <= pc_q;
  end

  a_no_overflow: assert property (@(posedge i_fetch_clk) disable iff (i_fetch_rst)
    !(rsp_take && fq_full));
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit with a randomized in-order memory model.
module tb_riscv_fetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, redirect, gnt, rvalid, valid, ready, req;
  logic [31:0] redirect_pc, addr, rdata, pc, instr;

  always #5 clk = ~clk;

  riscv_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_fetch_clk         (clk),
    .i_fetch_rst         (rst),
    .i_fetch_redirect    (redirect),
    .i_fetch_redirect_pc (redirect_pc),
    .o_fetch_imem_req    (req),
    .o_fetch_imem_addr   (addr),
    .i_fetch_imem_gnt    (gnt),
    .i_fetch_imem_rvalid (rvalid),
    .i_fetch_imem_rdata  (rdata),
    .o_fetch_valid       (valid),
    .o_fetch_pc          (pc),
    .o_fetch_instr       (instr),
    .i_fetch_ready       (ready)
  );

  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       pend[$];
  exp_t        expq[$];
  int          n_checks = 0, n_pass = 0;
  int unsigned cyc = 0;
  int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1;
  int          grant_cnt = 0, since_rst = -1, first_valid = -1;
  logic [31:0] exp_addr = RST_PC;
  bit          rst_prev = 0, redir_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Memory: random grant, in-order responses with random latency, at most one per cycle.
  initial begin
    int unsigned due;
    gnt = 0; rvalid = 0; rdata = 0;
    forever begin
      @(negedge clk);
      gnt = ($urandom_range(99) < gnt_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rvalid = 1; rdata = memf(pend[0].addr); void'(pend.pop_front());
      end else begin
        rvalid = 0; rdata = $urandom;
      end
      #1;
      if (rst) begin
        pend.delete(); exp_addr = RST_PC; grant_cnt = 0;
      end else begin
        if (req && gnt) begin
          chk("imem_addr", addr, exp_addr);
          due = cyc + $urandom_range(lat_max, lat_min);
          if (pend.size() > 0 && due <= pend[pend.size()-1].due) due = pend[pend.size()-1].due + 1;
          pend.push_back('{addr, due});
          expq.push_back('{exp_addr, memf(exp_addr)});
          exp_addr = exp_addr + 32'd4;
          grant_cnt++;
        end
        if (redirect) begin
          chk("req_low_on_redirect", {31'd0, req}, 32'd0);
          exp_addr = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every decode handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_prev) begin
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", addr, RST_PC);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
      end
      if (rst) begin
        expq.delete(); since_rst = -1; first_valid = -1; redir_prev = 0;
      end else begin
        since_rst++;
        if (valid && first_valid < 0) first_valid = since_rst;
        if (!valid) begin
          chk("empty_pc", pc, 32'd0);
          chk("empty_instr", instr, 32'd0);
        end
        if (redir_prev) chk("valid_after_redirect", {31'd0, valid}, 32'd0);
        if (valid && ready) begin
          if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_instr: got pc %h, expected no instruction", pc);
          end else begin
            e = expq.pop_front();
            chk("head_pc", pc, e.pc);
            chk("head_instr", instr, e.instr);
          end
        end
        if (redirect) expq.delete();
        redir_prev = redirect;
      end
      rst_prev = rst;
    end
  end

  task automatic step(input logic r, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    ready = r; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic run_random(input int n);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(2))
        0: tgt = 32'h0000_0103;
        1: tgt = 32'hFFFF_FFF4;
        default: tgt = $urandom;
      endcase
      step(($urandom_range(3) != 0), (since_rst >= 1) && ($urandom_range(31) == 0), tgt);
    end
  endtask

  initial begin
    int g0;
    rst = 1; ready = 0; redirect = 0; redirect_pc = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    // Stall decode: exactly DEPTH grants, then issue stops.
    repeat (20) step(0, 0, 0);
    #2;
    chk("grants_while_stalled", grant_cnt, DEPTH);
    chk("req_low_when_full", {31'd0, req}, 32'd0);
`ifdef RISCV_FETCH_BYPASS_EN
    chk("first_valid_cycle", first_valid, 32'd2);
`else
    chk("first_valid_cycle", first_valid, 32'd3);
`endif
    // Release: drain in order, then sustained 1 instr/cycle.
    repeat (4) step(1, 0, 0);
    g0 = grant_cnt;
    repeat (20) step(1, 0, 0);
    chk("throughput", 32'(grant_cnt - g0 >= 19), 32'd1);
    // Redirect coinciding with a response and a pop.
    step(1, 1, 32'h0000_0200);
    repeat (10) step(1, 0, 0);
    // Redirect to an unaligned target with requests in flight.
    lat_min = 2; lat_max = 2;
    repeat (10) step(1, 0, 0);
    step(1, 1, 32'h0000_0103);
    g0 = grant_cnt;
    repeat (12) step(1, 0, 0);
    chk("fetch_resumed", 32'(grant_cnt > g0), 32'd1);
    // PC wraparound.
    step(1, 1, 32'hFFFF_FFF4);
    repeat (12) step(1, 0, 0);
    // Randomized traffic.
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    run_random(3000);
    // Reset while draining.
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    repeat (10) step(1, 0, 0);
    step(1, 1, 32'h0000_0400);
    step(1, 0, 0); rst = 1;
    step(1, 0, 0); rst = 0;
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    run_random(300);
    repeat (10) step(1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
